// File: rtl/dev_bus_pkg.sv
// Shared definitions for the peripheral device bus: address map, access
// sequencer states, the latched request record and the device-hit decode.
package dev_bus_pkg;

  localparam logic [31:0] DEV0_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEV1_BASE = 32'h0000_7F10;
  localparam int          DEV_WORDS = 3;

  // Fixed four-step access sequence; the encoding doubles as the 2-bit state set.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } busState_t;

  // One master's access as captured at grant time.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
  } busReq_t;

  // True only for an exact word address of Timer0 or Timer1 (full 32-bit compare).
  function automatic logic dev_hit(input logic [31:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEV_WORDS; i++) begin
      if ((addr == DEV0_BASE + 32'(4 * i)) || (addr == DEV1_BASE + 32'(4 * i))) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the id
// that was not granted last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic id
);

  // Purely combinational winner selection.
  always_comb begin
    valid = req0 | req1;
    id    = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Serialises accesses from two masters (M0 = CPU, M1 = loader/debug) onto the
// single bridge port. Each access walks IDLE -> GRANT -> ACCESS -> RESP; every
// bridge-facing output comes straight from a register.
module dev_bus_arbiter
  import dev_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic        m0_we,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic        m1_we,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] rdata,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWe,
  input  logic [31:0] PrRD,
  output logic        busy
);

  busState_t state, nextState;
  busReq_t   granted;   // access currently being serviced
  busReq_t   winner;    // candidate access from the picker, valid in IDLE
  logic      grantId;   // 0 = M0, 1 = M1
  logic      grantHit;  // latched dev_hit of the granted address
  logic      lastId;    // most recently granted id; 1 out of reset so M0 wins the first tie
  logic      pickValid;
  logic      pickId;

  rr_pick2 uPick (
    .req0  (m0_req),
    .req1  (m1_req),
    .last  (lastId),
    .valid (pickValid),
    .id    (pickId)
  );

  // Mux the winning master's address/data/direction for capture at grant.
  always_comb begin
    winner = '0;
    if (pickId) begin
      winner.addr = m1_addr;
      winner.wd   = m1_wd;
      winner.we   = m1_we;
    end else begin
      winner.addr = m0_addr;
      winner.wd   = m0_wd;
      winner.we   = m0_we;
    end
  end

  // State register; reset is synchronous and wins from any state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and busy decode; requests are only looked at in IDLE.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned and infers a latch.
    nextState = state;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (pickValid) nextState = GRANT;
      end
      GRANT:   nextState = ACCESS;
      ACCESS:  nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: grant capture, one-cycle write strobe, read capture and response pulses.
  always_ff @(posedge clk) begin
    // NOTE: every register here is a plain flop (no memories), so all of them take a reset value.
    if (reset) begin
      granted  <= '0;
      grantId  <= 1'b0;
      grantHit <= 1'b0;
      lastId   <= 1'b1;
      rdata    <= '0;
      PrWe     <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
    end else begin
      // High during ACCESS only, and never for an address outside the device map.
      PrWe   <= (state == GRANT) & granted.we & grantHit;
      m0_ack <= (state == ACCESS) & ~grantId;
      m1_ack <= (state == ACCESS) &  grantId;
      m0_err <= (state == ACCESS) & ~grantId & ~grantHit;
      m1_err <= (state == ACCESS) &  grantId & ~grantHit;

      if ((state == IDLE) && pickValid) begin
        granted  <= winner;
        grantId  <= pickId;
        grantHit <= dev_hit(winner.addr);
        lastId   <= pickId;
      end

      // Captured on writes too; a miss reads back as zero.
      if (state == ACCESS) begin
        rdata <= grantHit ? PrRD : '0;
      end
    end
  end

  // Bridge address/data are the grant registers themselves.
  assign PrAddr = granted.addr;
  assign PrWD   = granted.wd;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Directed bench for dev_bus_arbiter: single-master reads/writes, misses,
// round-robin contention and reset in the middle of an access.
module tb_dev_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd;
  logic        m0_we, m1_we;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] rdata, PrAddr, PrWD, PrRD;
  logic        PrWe, busy;
  logic [31:0] prdModel;

  int checks = 0;
  int errors = 0;

  assign PrRD = prdModel;

  always #5 clk = ~clk;

  dev_bus_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .m0_req  (m0_req),
    .m0_addr (m0_addr),
    .m0_wd   (m0_wd),
    .m0_we   (m0_we),
    .m1_req  (m1_req),
    .m1_addr (m1_addr),
    .m1_wd   (m1_wd),
    .m1_we   (m1_we),
    .m0_ack  (m0_ack),
    .m1_ack  (m1_ack),
    .m0_err  (m0_err),
    .m1_err  (m1_err),
    .rdata   (rdata),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrWe    (PrWe),
    .PrRD    (PrRD),
    .busy    (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      $error("check %s", tag);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_addr = '0; m0_wd = '0; m0_we = 1'b0;
    m1_req = 1'b0; m1_addr = '0; m1_wd = '0; m1_we = 1'b0;
    prdModel = 32'hFFFF_FFFF;
    tick();
    tick();

    // Reset state.
    check("rst_busy",   busy,   0);
    check("rst_praddr", PrAddr, 0);
    check("rst_prwd",   PrWD,   0);
    check("rst_prwe",   PrWe,   0);
    check("rst_ack",    {m0_ack, m1_ack}, 0);
    check("rst_err",    {m0_err, m1_err}, 0);
    check("rst_rdata",  rdata,  0);
    reset = 1'b0;

    // M0 reads 0x7F04; cycle 0 = IDLE with req sampled.
    prdModel = 32'h0000_1234;
    m0_req = 1'b1; m0_addr = 32'h7F04; m0_wd = 32'hDEAD_BEEF; m0_we = 1'b0;
    check("rd_c0_busy", busy, 0);
    tick();
    check("rd_c1_busy",   busy,   1);
    check("rd_c1_praddr", PrAddr, 32'h7F04);
    check("rd_c1_prwe",   PrWe,   0);
    check("rd_c1_ack",    m0_ack, 0);
    tick();
    check("rd_c2_busy", busy,   1);
    check("rd_c2_prwe", PrWe,   0);
    check("rd_c2_ack",  m0_ack, 0);
    tick();
    check("rd_c3_busy",  busy,   1);
    check("rd_c3_ack0",  m0_ack, 1);
    check("rd_c3_ack1",  m1_ack, 0);
    check("rd_c3_err",   m0_err, 0);
    check("rd_c3_rdata", rdata,  32'h1234);
    check("rd_c3_prwe",  PrWe,   0);
    m0_req = 1'b0;
    tick();
    check("rd_c4_busy", busy,   0);
    check("rd_c4_ack",  m0_ack, 0);

    // M1 writes 0xA5 to 0x7F10; rdata still captures the bridge on a write.
    prdModel = 32'h0000_0055;
    m1_req = 1'b1; m1_addr = 32'h7F10; m1_wd = 32'hA5; m1_we = 1'b1;
    tick();
    check("wr_c1_praddr", PrAddr, 32'h7F10);
    check("wr_c1_prwd",   PrWD,   32'hA5);
    check("wr_c1_prwe",   PrWe,   0);
    tick();
    check("wr_c2_praddr", PrAddr, 32'h7F10);
    check("wr_c2_prwd",   PrWD,   32'hA5);
    check("wr_c2_prwe",   PrWe,   1);
    tick();
    check("wr_c3_prwe",  PrWe,   0);
    check("wr_c3_ack1",  m1_ack, 1);
    check("wr_c3_ack0",  m0_ack, 0);
    check("wr_c3_err",   m1_err, 0);
    check("wr_c3_rdata", rdata,  32'h55);
    m1_req = 1'b0;
    tick();
    check("wr_c4_ack", m1_ack, 0);

    // M0 writes the unmapped word 0x7F0C: no strobe, err with ack.
    prdModel = 32'hFFFF_FFFF;
    m0_req = 1'b1; m0_addr = 32'h7F0C; m0_wd = 32'h77; m0_we = 1'b1;
    tick();
    check("mw_c1_prwe", PrWe, 0);
    tick();
    check("mw_c2_prwe", PrWe, 0);
    tick();
    check("mw_c3_ack",   m0_ack, 1);
    check("mw_c3_err",   m0_err, 1);
    check("mw_c3_prwe",  PrWe,   0);
    check("mw_c3_rdata", rdata,  0);
    m0_we = 1'b0;                      // same address, now a read, re-requested back to back
    tick();
    check("mw_c4_err", m0_err, 0);
    tick();
    tick();
    tick();
    check("mr_c3_ack",   m0_ack, 1);
    check("mr_c3_err",   m0_err, 1);
    check("mr_c3_rdata", rdata,  0);

    // Upper address bits must take part in the compare: 0x0001_7F00 misses.
    m0_addr = 32'h0001_7F00;
    tick();
    tick();
    tick();
    tick();
    check("hi_c3_err",   m0_err, 1);
    check("hi_c3_rdata", rdata,  0);

    // Last mapped word 0x7F18 hits.
    prdModel = 32'h0000_ABCD;
    m0_addr = 32'h7F18;
    tick();
    tick();
    tick();
    tick();
    check("top_c3_ack",   m0_ack, 1);
    check("top_c3_err",   m0_err, 0);
    check("top_c3_rdata", rdata,  32'hABCD);
    m0_req = 1'b0;
    tick();

    // Contention straight out of reset: M0, M1, M0, M1 with acks at 3, 7, 11, 15.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    prdModel = 32'h0BAD_F00D;
    m0_req = 1'b1; m0_addr = 32'h7F00; m0_we = 1'b0; m0_wd = 32'h0;
    m1_req = 1'b1; m1_addr = 32'h7F14; m1_we = 1'b1; m1_wd = 32'h1111;
    for (int c = 1; c <= 15; c++) begin
      tick();
      check($sformatf("rr_c%0d_ack0", c), m0_ack, (c == 3 || c == 11) ? 1 : 0);
      check($sformatf("rr_c%0d_ack1", c), m1_ack, (c == 7 || c == 15) ? 1 : 0);
      check($sformatf("rr_c%0d_prwe", c), PrWe,   (c == 6 || c == 14) ? 1 : 0);
      if ((c % 4 == 1) || (c % 4 == 2)) begin
        check($sformatf("rr_c%0d_praddr", c), PrAddr, ((c / 4) % 2 == 0) ? 32'h7F00 : 32'h7F14);
      end
      if (c % 4 == 3) begin
        check($sformatf("rr_c%0d_rdata", c), rdata, 32'h0BAD_F00D);
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    check("rr_end_busy", busy, 0);

    // Reset lands during M1's ACCESS cycle: no ack, no strobe afterwards.
    m1_req = 1'b1; m1_addr = 32'h7F14; m1_wd = 32'h99; m1_we = 1'b1;
    tick();
    tick();
    check("ra_c2_prwe", PrWe, 1);
    reset = 1'b1;
    tick();
    check("ra_c3_busy",   busy,   0);
    check("ra_c3_prwe",   PrWe,   0);
    check("ra_c3_ack1",   m1_ack, 0);
    check("ra_c3_praddr", PrAddr, 0);
    check("ra_c3_rdata",  rdata,  0);

    // After reset the tie goes to M0.
    reset = 1'b0;
    prdModel = 32'h0000_0042;
    m0_req = 1'b1; m0_addr = 32'h7F08; m0_we = 1'b0;
    tick();
    check("tie_c1_praddr", PrAddr, 32'h7F08);
    check("tie_c1_ack1",   m1_ack, 0);
    tick();
    check("tie_c2_prwe", PrWe, 0);
    tick();
    check("tie_c3_ack0",  m0_ack, 1);
    check("tie_c3_ack1",  m1_ack, 0);
    check("tie_c3_rdata", rdata,  32'h42);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
